// File: rtl/micro_uart1_pkg.sv
// Shared register map for the micro_uart1 receive FIFO: offsets, STATUS/CTRL
// bit positions and the code returned when DATA is read from an empty FIFO.
package micro_uart1_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  localparam int unsigned LVL_W          = 9;
  localparam int unsigned ST_EMPTY_BIT   = 16;
  localparam int unsigned ST_FULL_BIT    = 17;
  localparam int unsigned ST_OVR_BIT     = 18;
  localparam int unsigned ST_TO_BIT      = 19;
  localparam int unsigned CTRL_IRQEN_BIT = 24;
  localparam int unsigned CTRL_FLUSH_BIT = 25;

  localparam logic [31:0] DATA_EMPTY_CODE = 32'h0000_0100;

  // Word-select from address bits [3:2]; byte-lane bits are ignored.
  function automatic reg_sel_e reg_sel(input logic [1:0] word);
    return reg_sel_e'(word);
  endfunction

endpackage

// File: rtl/micro_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; caller must not push while full
// unless it pops in the same cycle. Flush overrides push and pop.
module micro_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PTR_ONE;
      if (pop_i)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/micro_uart1_rxfifo.sv
// APB-mapped receive FIFO for micro_uart1 with overrun flag and level/OVR/TO
// interrupt. Idle timeout is built only with MICRO_UART1_RXFIFO_TIMEOUT_EN.
module micro_uart1_rxfifo
  import micro_uart1_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TO_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        apb_psel,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [3:0]  apb_paddr,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  reg_sel_e           sel;
  logic               access, rd_data, wr_status, wr_ctrl, flush, push, pop;
  logic               full, empty;
  logic [7:0]         head;
  logic [AW:0]        fifo_level;
  logic [LVL_W-1:0]   level;
  logic               ovr_q, ovr_d, to_q, irq_q, irq_d, irq_en_q, irq_en_d;
  logic [LVL_W-1:0]   thresh_q, thresh_d;

  assign sel       = reg_sel(apb_paddr[3:2]);
  assign access    = apb_psel & apb_penable;
  assign rd_data   = access & ~apb_pwrite & (sel == REG_DATA);
  assign wr_status = access &  apb_pwrite & (sel == REG_STATUS);
  assign wr_ctrl   = access &  apb_pwrite & (sel == REG_CTRL);
  assign flush     = wr_ctrl & apb_pwdata[CTRL_FLUSH_BIT];
  assign pop       = rd_data & ~empty;
  assign push      = rx_valid & ~flush & (~full | pop);
  assign level     = LVL_W'(fifo_level);

  micro_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (rx_data),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_comb begin
    ovr_d = ovr_q;
    if (wr_status && apb_pwdata[ST_OVR_BIT]) ovr_d = 1'b0;
    if (rx_valid && full && !pop)            ovr_d = 1'b1;
    thresh_d = thresh_q;
    irq_en_d = irq_en_q;
    if (wr_ctrl) begin
      thresh_d = apb_pwdata[LVL_W-1:0];
      irq_en_d = apb_pwdata[CTRL_IRQEN_BIT];
    end
    irq_d = irq_en_q & (((level >= thresh_q) & (thresh_q != '0)) | ovr_q | to_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= LVL_W'(1);
    end else begin
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
    end
  end

`ifdef MICRO_UART1_RXFIFO_TIMEOUT_EN
  localparam int unsigned CW     = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TO_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_d;

  // Counter saturates at the limit and TO sets only on the reaching edge, so a
  // software clear while the FIFO stays idle is not undone the next cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (push || pop || flush || level == '0) cnt_d = '0;
    else if (cnt_q != TO_LIM)                cnt_d = cnt_q + CW'(1);
    to_d = to_q;
    if (wr_status && apb_pwdata[ST_TO_BIT]) to_d = 1'b0;
    if (cnt_d == TO_LIM && cnt_q != TO_LIM) to_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`else
  logic unused_to_cfg;
  assign to_q          = 1'b0;
  assign unused_to_cfg = (TO_CYCLES == 0);
`endif

  always_comb begin
    apb_prdata = '0;
    case (sel)
      REG_DATA:   apb_prdata = empty ? DATA_EMPTY_CODE : {24'h0, head};
      REG_STATUS: begin
        apb_prdata[LVL_W-1:0]    = level;
        apb_prdata[ST_EMPTY_BIT] = empty;
        apb_prdata[ST_FULL_BIT]  = full;
        apb_prdata[ST_OVR_BIT]   = ovr_q;
        apb_prdata[ST_TO_BIT]    = to_q;
      end
      REG_CTRL: begin
        apb_prdata[LVL_W-1:0]      = thresh_q;
        apb_prdata[CTRL_IRQEN_BIT] = irq_en_q;
      end
      default:    apb_prdata = '0;
    endcase
  end

  assign irq = irq_q;

  logic unused_bits;
  assign unused_bits = ^{apb_paddr[1:0], apb_pwdata};

endmodule
